// File: rtl/distance_table_rom.sv
// distance_table_rom
// Registered lookup of the scaled Manhattan distance between two cities of
// the route solver. City coordinates come from a closed-form generator, so
// the "ROM" is evaluated combinationally from the address and registered.
// That gives a 1-cycle read latency with one result per clock.

module distance_table_rom #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 9,
    parameter int SCALE  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    // Each address field selects one 5-bit city index.
    localparam int CITY_W = ADDR_W / 2;
    // SCALE is a power of two, so the multiply reduces to a left shift.
    localparam int SHIFT  = $clog2(SCALE);

    logic [CITY_W-1:0] city  [2];
    logic [CITY_W-1:0] x_pos [2];
    logic [CITY_W-1:0] y_pos [2];

    logic [CITY_W-1:0] dx;
    logic [CITY_W-1:0] dy;
    logic [CITY_W:0]   manhattan;
    logic [DATA_W-1:0] manhattan_ext;
    logic [DATA_W-1:0] dout_next;

    // Coordinate generators, one per address field. The 5-bit arithmetic
    // wraps naturally, which implements the mod-32 reduction.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_city
            assign city[gi]  = addr[gi*CITY_W +: CITY_W];
            assign x_pos[gi] = CITY_W'(city[gi] * CITY_W'(11) + CITY_W'(3));
            assign y_pos[gi] = CITY_W'(city[gi] * CITY_W'(19) + CITY_W'(5));
        end
    endgenerate

    // Absolute differences and the scaled sum. Taking the absolute value
    // makes the result symmetric in the two fields, so the swapped
    // addresses need no special handling.
    always_comb begin
        dx            = (x_pos[1] >= x_pos[0]) ? (x_pos[1] - x_pos[0]) : (x_pos[0] - x_pos[1]);
        dy            = (y_pos[1] >= y_pos[0]) ? (y_pos[1] - y_pos[0]) : (y_pos[0] - y_pos[1]);
        manhattan     = {1'b0, dx} + {1'b0, dy};
        manhattan_ext = DATA_W'(manhattan);
        dout_next     = manhattan_ext << SHIFT;
    end

    // Output register: it clears on a synchronous reset and otherwise
    // loads the distance for the address present at each edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= dout_next;
        end
    end

endmodule

// File: tb/tb_distance_table_rom.sv
// Testbench for distance_table_rom: directed vector table, back-to-back and
// reset sequences, and a full address sweep against a formula model.

module tb_distance_table_rom;

    logic       clk;
    logic       rst_n;
    logic [9:0] addr;
    logic [8:0] dout;

    int errors = 0;
    int checks = 0;

    distance_table_rom dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        int         expect_val;
        string      name;
    } vec_t;

    vec_t vecs [6];
    int   sweep [1024];

    function automatic int d_model(input int a, input int b);
        int xa, xb, ya, yb, dxm, dym;
        xa  = (11 * a + 3) % 32;
        xb  = (11 * b + 3) % 32;
        ya  = (19 * a + 5) % 32;
        yb  = (19 * b + 5) % 32;
        dxm = (xa > xb) ? xa - xb : xb - xa;
        dym = (ya > yb) ? ya - yb : yb - ya;
        return 8 * (dxm + dym);
    endfunction

    task automatic check(input string name, input int act, input int exp_val);
        checks++;
        if (act !== exp_val) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_val);
        end else begin
            $display("ok   %s: dout=%0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keeps the run bounded no matter what the design does.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{10'h001, 240, "vec_0_1"};
        vecs[1] = '{10'h043, 320, "vec_2_3"};
        vecs[2] = '{10'h01F, 272, "vec_0_31"};
        vecs[3] = '{10'h3E0, 272, "vec_31_0_swapped"};
        vecs[4] = '{10'h021,   0, "vec_diag_1_1"};
        vecs[5] = '{10'h3FF,   0, "vec_diag_31_31"};

        // Reset with a nonzero address: reset must force zero.
        rst_n = 1'b0;
        addr  = 10'h001;
        tick();
        tick();
        check("reset_state", int'(dout), 0);

        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            addr = vecs[i].addr;
            tick();
            check(vecs[i].name, int'(dout), vecs[i].expect_val);
        end

        // Back-to-back addresses, one result per cycle.
        addr = 10'h001;
        tick();
        addr = 10'h043;
        check("b2b_first", int'(dout), 240);
        tick();
        addr = 10'h01F;
        check("b2b_second", int'(dout), 320);
        tick();
        check("b2b_third", int'(dout), 272);

        // Mid-stream reset with the address held at 0x001.
        addr = 10'h001;
        tick();
        check("pre_reset", int'(dout), 240);
        rst_n = 1'b0;
        #2;
        check("reset_between_edges_no_effect", int'(dout), 240);
        tick();
        check("reset_edge_clears", int'(dout), 0);
        rst_n = 1'b1;
        #2;
        check("release_between_edges_holds", int'(dout), 0);
        tick();
        check("first_edge_after_reset", int'(dout), 240);

        // Full sweep against the model.
        for (int i = 0; i < 1024; i++) begin
            addr = 10'(i);
            tick();
            sweep[i] = int'(dout);
            checks++;
            if (sweep[i] !== d_model(i / 32, i % 32)) begin
                errors++;
                $display("FAIL sweep addr=0x%03h: got %0d, expected %0d",
                         i, sweep[i], d_model(i / 32, i % 32));
            end
        end
        $display("ok   sweep: 1024 addresses compared");

        // Structural properties over the captured table.
        for (int a = 0; a < 32; a++) begin
            checks++;
            if (sweep[a * 32 + a] != 0) begin
                errors++;
                $display("FAIL diag a=%0d: got %0d, expected 0", a, sweep[a * 32 + a]);
            end
            for (int b = a + 1; b < 32; b++) begin
                checks++;
                if (sweep[a * 32 + b] != sweep[b * 32 + a]) begin
                    errors++;
                    $display("FAIL symmetry (%0d,%0d): got %0d, expected %0d",
                             a, b, sweep[b * 32 + a], sweep[a * 32 + b]);
                end
            end
        end
        for (int i = 0; i < 1024; i++) begin
            checks++;
            if (sweep[i] > 496) begin
                errors++;
                $display("FAIL bound addr=0x%03h: got %0d, required <= 496", i, sweep[i]);
            end
        end
        $display("ok   properties: diagonal, symmetry, bound compared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
